// File: rtl/uart_rx_pkt_parser.sv
// uart_rx_pkt_parser: frames UART bytes as SOF,LEN,payload,XOR checksum and forwards verified payloads.
module uart_rx_pkt_parser #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN = 16,
  parameter logic [DATA_WIDTH-1:0] SOF = 8'hA5,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  input  logic                  IN_ERR,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  OUT_LAST,
  output logic                  PKT_OK,
  output logic                  CHK_ERR,
  output logic                  LEN_ERR,
  output logic                  TO_ERR,
  output logic                  RX_ERR,
  output logic                  OVERRUN,
  output logic [2:0]            STATE_DBG
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK = 3'd3,
    S_DRAIN = 3'd4
  } state_t;
  state_t r_state, w_next;
  logic [DATA_WIDTH-1:0] r_buf [MAX_LEN];
  logic [DATA_WIDTH-1:0] r_chk;
  logic [PW-1:0] r_last, r_wr, r_rd;
  logic [TW-1:0] r_to;
  logic w_acc, w_timed, w_to, w_len_ok, w_ok, w_cerr, w_lerr, w_rerr, w_ovr;
  assign w_acc = IN_VALID & ~IN_ERR;
  assign w_timed = (r_state == S_LEN) | (r_state == S_PAYLOAD) | (r_state == S_CHK);
  assign w_to = w_timed & ~IN_VALID & (r_to == TW'(TIMEOUT_CYC - 1));
  assign w_len_ok = (IN_DATA != '0) && (IN_DATA <= DATA_WIDTH'(MAX_LEN));
  always_comb begin
    w_next = r_state;
    w_ok = 1'b0;
    w_cerr = 1'b0;
    w_lerr = 1'b0;
    w_rerr = 1'b0;
    w_ovr = 1'b0;
    case (r_state)
      S_IDLE: w_next = (w_acc && IN_DATA == SOF) ? S_LEN : S_IDLE;
      S_LEN: begin
        w_next = !w_acc ? S_LEN : w_len_ok ? S_PAYLOAD : S_IDLE;
        w_lerr = w_acc & ~w_len_ok;
      end
      S_PAYLOAD: w_next = (w_acc && r_wr == r_last) ? S_CHK : S_PAYLOAD;
      S_CHK: begin
        w_ok = w_acc & (IN_DATA == r_chk);
        w_cerr = w_acc & (IN_DATA != r_chk);
        w_next = w_ok ? S_DRAIN : w_cerr ? S_IDLE : S_CHK;
      end
      S_DRAIN: begin
        w_ovr = IN_VALID;
        w_next = (OUT_READY && r_rd == r_last) ? S_IDLE : S_DRAIN;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_timed && IN_VALID && IN_ERR) begin
      w_rerr = 1'b1;
      w_next = S_IDLE;
    end
    if (w_to) w_next = S_IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_chk <= '0;
      r_last <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_to <= '0;
    end else begin
      r_state <= w_next;
      r_to <= (w_timed && !IN_VALID) ? r_to + TW'(1) : '0;
      r_rd <= (r_state != S_DRAIN) ? '0 : OUT_READY ? r_rd + PW'(1) : r_rd;
      if (r_state == S_LEN && w_acc) begin
        r_last <= PW'(IN_DATA - 1);
        r_chk <= IN_DATA;
        r_wr <= '0;
      end
      if (r_state == S_PAYLOAD && w_acc) begin
        r_chk <= r_chk ^ IN_DATA;
        r_wr <= r_wr + PW'(1);
      end
    end
  end
  // Payload storage needs no reset: it is only read in DRAIN, which requires a fresh fill.
  always_ff @(posedge CLK)
    if (r_state == S_PAYLOAD && w_acc) r_buf[r_wr] <= IN_DATA;
  assign OUT_VALID = (r_state == S_DRAIN);
  assign OUT_DATA = OUT_VALID ? r_buf[r_rd] : '0;
  assign OUT_LAST = OUT_VALID && (r_rd == r_last);
  assign STATE_DBG = r_state;
  assign PKT_OK = w_ok & RESET;
  assign CHK_ERR = w_cerr & RESET;
  assign LEN_ERR = w_lerr & RESET;
  assign TO_ERR = w_to & RESET;
  assign RX_ERR = w_rerr & RESET;
  assign OVERRUN = w_ovr & RESET;
endmodule
